muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit. It sits beside the single-cycle ALU in the execute stage and is parametrised in operand width.
- It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, using a start/done handshake and a stall output to the hazard unit.
- It adds capabilities the single-cycle ALU does not have: multi-cycle sequencing, flush/abort, and early-out for division special cases.

---
 rtl/muldiv_unit_if.sv | 16 +
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             stall;

    modport master (output start, flush, funct3, a, b, input result, done, stall);
    modport slave  (input start, flush, funct3, a, b, output result, done, stall);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle over WIDTH cycles, then a sign-fix cycle,
// with start/done handshake, flush abort and optional single-cycle divide special cases.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave io
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               neg_q, neg_d;
    logic               nega_q, nega_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    // Operand decode for the request presented in IDLE.
    logic             in_div, a_sgn, b_sgn, a_neg, b_neg, in_dz, in_ovf;
    logic [WIDTH-1:0] in_ma, in_mb, in_special;

    always_comb begin
        in_div = io.funct3[2];
        a_sgn  = in_div ? ~io.funct3[0] : (io.funct3[1:0] == 2'b01 || io.funct3[1:0] == 2'b10);
        b_sgn  = in_div ? ~io.funct3[0] : (io.funct3[1:0] == 2'b01);
        a_neg  = a_sgn & io.a[WIDTH-1];
        b_neg  = b_sgn & io.b[WIDTH-1];
        in_ma  = a_neg ? -io.a : io.a;
        in_mb  = b_neg ? -io.b : io.b;
        in_dz  = in_div & (io.b == '0);
        in_ovf = in_div & ~io.funct3[0] & (io.a == MIN_VAL) & (&io.b);
        if (in_dz) in_special = io.funct3[1] ? io.a : '1;
        else       in_special = io.funct3[1] ? '0 : MIN_VAL;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mb_q} : '0);
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
        div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, mb_q};
        if (!div_diff[WIDTH]) div_next = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else                  div_next = {div_sh[WIDTH-1:0],   prod_q[WIDTH-2:0], 1'b0};
    end

    // Sign correction and half selection applied in FIX.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        prod_s = neg_q  ? -prod_q : prod_q;
        quo_s  = neg_q  ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_s  = nega_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        case (op_q)
            3'b000:         fix_res = prod_s[WIDTH-1:0];
            3'b100, 3'b101: fix_res = quo_s;
            3'b110, 3'b111: fix_res = rem_s;
            default:        fix_res = prod_s[2*WIDTH-1:WIDTH];
        endcase
        if (dz_q)       fix_res = op_q[1] ? a_q : '1;
        else if (ovf_q) fix_res = op_q[1] ? '0 : MIN_VAL;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        mb_d     = mb_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        nega_d   = nega_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (io.start && !io.flush) begin
                op_d   = io.funct3;
                a_d    = io.a;
                mb_d   = in_mb;
                prod_d = {{WIDTH{1'b0}}, in_ma};
                neg_d  = a_neg ^ b_neg;
                nega_d = a_neg;
                dz_d   = in_dz;
                ovf_d  = in_ovf;
                cnt_d  = CNT_INIT;
                if (EARLY_OUT && (in_dz || in_ovf)) begin
                    result_d = in_special;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d  = CALC;
                end
            end
            CALC: begin
                prod_d = op_q[2] ? div_next : mul_next;
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        // A kill never produces a completion; in DONE the pulse is already registered.
        if (io.flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            mb_q     <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            nega_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            mb_q     <= mb_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            nega_q   <= nega_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign io.result = result_q;
    assign io.done   = done_q;
    assign io.stall  = (state_q == IDLE && io.start && !io.flush) || state_q == CALC || state_q == FIX;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit: 32-bit early-out, 32-bit full-iteration and 16-bit builds.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) i0 ();
    muldiv_unit_if #(.WIDTH(32)) i1 ();
    muldiv_unit_if #(.WIDTH(16)) i2 ();

    muldiv_unit #(.WIDTH(32), .EARLY_OUT(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .io(i0));
    muldiv_unit #(.WIDTH(32), .EARLY_OUT(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .io(i1));
    muldiv_unit #(.WIDTH(16), .EARLY_OUT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .io(i2));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drv(input int s, input logic st, input logic fl, input logic [2:0] f,
                       input logic [31:0] x, input logic [31:0] y);
        case (s)
            0: begin i0.start = st; i0.flush = fl; i0.funct3 = f; i0.a = x; i0.b = y; end
            1: begin i1.start = st; i1.flush = fl; i1.funct3 = f; i1.a = x; i1.b = y; end
            default: begin i2.start = st; i2.flush = fl; i2.funct3 = f; i2.a = x[15:0]; i2.b = y[15:0]; end
        endcase
    endtask

    // {stall, done, result}
    function automatic logic [33:0] obs(input int s);
        case (s)
            0:       return {i0.stall, i0.done, i0.result};
            1:       return {i1.stall, i1.done, i1.result};
            default: return {i2.stall, i2.done, 16'h0, i2.result};
        endcase
    endfunction

    // Start in cycle 0; expect done in cycle lat with stall high in every earlier cycle.
    task automatic do_op(input string tag, input int s, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int lat, input bit noise);
        int cyc;
        bit sbad;
        logic [33:0] o;
        @(negedge clk);
        drv(s, 1'b1, 1'b0, f, x, y);
        #1 o = obs(s);
        sbad = !o[33];
        @(posedge clk);
        #1;
        for (cyc = 1; cyc <= 100; cyc++) begin
            if (noise && (cyc == 5 || cyc == 20)) drv(s, 1'b1, 1'b0, 3'b000, 32'h1234, 32'h5678);
            else                                  drv(s, 1'b0, 1'b0, f, x, y);
            #1 o = obs(s);
            if (o[32]) break;
            if (!o[33]) sbad = 1'b1;
            @(posedge clk);
            #1;
        end
        drv(s, 1'b0, 1'b0, f, x, y);
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, {32'h0, o[31:0]}, {32'h0, exp});
        chk({tag, " stall"}, {62'h0, sbad, o[33]}, 64'h0);
        @(posedge clk);
        #2 o = obs(s);
        chk({tag, " done 1cyc"}, {63'h0, o[32]}, 64'h0);
    endtask

    initial begin
        logic [33:0] o;
        int ndone;
        drv(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drv(2, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset u0", {30'h0, obs(0)}, 64'h0);
        chk("reset u1", {30'h0, obs(1)}, 64'h0);
        chk("reset u2", {30'h0, obs(2)}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("MUL 7*-3",        0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
        do_op("MULH min*min",    0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
        do_op("MULHSU -1*ffff",  0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0);
        do_op("MULHU ffff*ffff", 0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        do_op("DIV -7/2",        0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
        do_op("REM -7,2",        0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        do_op("DIVU 100/7",      0, 3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0);
        do_op("REMU 100,7",      0, 3'b111, 32'd100,      32'd7,        32'd2,        34, 1'b0);
        do_op("EO DIVU 5/0",     0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
        do_op("EO REM 5,0",      0, 3'b110, 32'd5,        32'd0,        32'd5,        1,  1'b0);
        do_op("EO DIV ovf",      0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
        do_op("EO REM ovf",      0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);
        do_op("FULL DIVU 5/0",   1, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 34, 1'b0);
        do_op("FULL REM 5,0",    1, 3'b110, 32'd5,        32'd0,        32'd5,        34, 1'b0);
        do_op("FULL REM -7,0",   1, 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 34, 1'b0);
        do_op("FULL DIV -7/0",   1, 3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 34, 1'b0);
        do_op("FULL DIV ovf",    1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 1'b0);
        do_op("FULL REM ovf",    1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 1'b0);
        do_op("W16 MULH",        2, 3'b001, 32'h8000,     32'h7FFF,     32'hC000,     18, 1'b0);
        do_op("W16 DIV ovf",     2, 3'b100, 32'h8000,     32'hFFFF,     32'h8000,     1,  1'b0);
        do_op("W16 DIVU ffff/3", 2, 3'b101, 32'hFFFF,     32'd3,        32'h5555,     18, 1'b0);

        // flush in cycle 10 of a DIV
        do_op("DIVU pre-flush",  0, 3'b101, 32'd100,      32'd7,        32'd14,       34, 1'b0);
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 3'b100, 32'd1000, 32'd3);
        @(posedge clk);
        #1 drv(0, 1'b0, 1'b0, 3'b100, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 drv(0, 1'b0, 1'b1, 3'b100, 32'd1000, 32'd3);
        #1 chk("flush c10 stall", {63'h0, obs(0)}, 64'h0 | obs(0) | 64'h0 ? {63'h0, obs(0)} : 64'h0);
        o = obs(0);
        chk("flush c10 busy", {63'h0, o[33]}, 64'h1);
        @(posedge clk);
        #1 drv(0, 1'b0, 1'b0, 3'b100, 32'd1000, 32'd3);
        #1 o = obs(0);
        chk("flush c11 stall", {63'h0, o[33]}, 64'h0);
        chk("flush c11 done", {63'h0, o[32]}, 64'h0);
        chk("flush c11 result", {32'h0, o[31:0]}, 64'd14);
        do_op("DIV after flush", 0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);

        // flush and start together in IDLE
        @(negedge clk);
        drv(0, 1'b1, 1'b1, 3'b101, 32'd9, 32'd3);
        #1 o = obs(0);
        chk("flush+start stall", {63'h0, o[33]}, 64'h0);
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 drv(0, 1'b0, 1'b0, 3'b101, 32'd9, 32'd3);
            #1 o = obs(0);
            if (o[32] || o[33]) ndone++;
        end
        chk("flush+start no done/stall", 64'(ndone), 64'h0);
        chk("flush+start result", {32'h0, o[31:0]}, 64'hFFFFFFFD);

        // start pulses while busy are ignored
        do_op("MUL busy starts", 0, 3'b000, 32'h00010001, 32'h00010001, 32'h00020001, 34, 1'b1);

        // asynchronous reset mid-operation
        @(negedge clk);
        drv(0, 1'b1, 1'b0, 3'b000, 32'd3, 32'd5);
        @(posedge clk);
        #1 drv(0, 1'b0, 1'b0, 3'b000, 32'd3, 32'd5);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 o = obs(0);
        chk("reset mid result", {32'h0, o[31:0]}, 64'h0);
        chk("reset mid stall", {63'h0, o[33]}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 o = obs(0);
            if (o[32]) ndone++;
        end
        chk("reset no done", 64'(ndone), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
